// File: rtl/shifter_left_32bits_pkg.sv
// rtl/shifter_left_32bits_pkg.sv - shared constants and types for the normalisation stage
// Purpose: widths, normalisation target and datapath typedefs used by
//          shifter_left_32bits and its subtractor sub-block.
// Ports:   none (package).
package shifter_left_32bits_pkg;

   localparam int SIG_W   = 32;
   localparam int EXP_W   = 8;
   localparam int SHAMT_W = 5;

   // Bit position the leading one is normalised to.
   localparam logic [EXP_W-1:0] TARGET = 8'd23;

   typedef logic [SIG_W-1:0] sig_t;
   typedef logic [EXP_W-1:0] exp_t;

endpackage

// File: rtl/shifter_left_32bits_full_subtractor_8bits.sv
// rtl/shifter_left_32bits_full_subtractor_8bits.sv - 8-bit ripple full subtractor
// Purpose: diff = a - b - bin (modulo 256) with borrow-out, built from a
//          chain of 1-bit full subtractors.
// Ports:   a, b    in  8  minuend / subtrahend
//          bin     in  1  borrow-in
//          diff    out 8  difference
//          bout    out 1  borrow-out of the MSB cell
module full_subtractor_8bits
   import shifter_left_32bits_pkg::*;
(
   input  logic [EXP_W-1:0] a,
   input  logic [EXP_W-1:0] b,
   input  logic             bin,
   output logic [EXP_W-1:0] diff,
   output logic             bout
);

   // borrow[k] is the borrow into cell k; borrow[EXP_W] leaves the MSB.
   logic [EXP_W:0] borrow;

   assign borrow[0] = bin;

   for (genvar k = 0; k < EXP_W; k++) begin : g_cell
      assign diff[k]     = a[k] ^ b[k] ^ borrow[k];
      assign borrow[k+1] = (~a[k] & b[k]) | (~(a[k] ^ b[k]) & borrow[k]);
   end

   assign bout = borrow[EXP_W];

endmodule

// File: rtl/shifter_left_32bits.sv
// rtl/shifter_left_32bits.sv - registered left-normalisation of a 32-bit significand
// Purpose: shifts sig left so its leading one lands at bit TARGET and
//          lowers the exponent by the same amount; one register stage.
// Ports:   clk        in  1   rising-edge clock
//          rst        in  1   synchronous active-high reset
//          in_valid   in  1   input sample valid
//          sig        in  32  unnormalised significand
//          ex_a       in  8   exponent of sig
//          lead       in  6   leading-one index (32..63 = zero significand)
//          out_valid  out 1   registered in_valid
//          sig_sub    out 32  normalised significand
//          ex_sub     out 8   adjusted exponent
//          shift_neg  out 1   lead above TARGET, no shift applied
//          ex_borrow  out 1   exponent underflow borrow
module shifter_left_32bits
   import shifter_left_32bits_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] sig,
   input  logic [7:0]  ex_a,
   input  logic [5:0]  lead,
   output logic        out_valid,
   output logic [31:0] sig_sub,
   output logic [7:0]  ex_sub,
   output logic        shift_neg,
   output logic        ex_borrow
);

   exp_t shamt8;
   logic b0;
   exp_t ex_diff;
   logic ex_bout;
   sig_t shifted;

   logic out_valid_q;
   sig_t sig_sub_q,   sig_sub_d;
   exp_t ex_sub_q,    ex_sub_d;
   logic shift_neg_q, shift_neg_d;
   logic ex_borrow_q, ex_borrow_d;

   // shamt8 = TARGET - lead; a borrow means lead is above the target
   // (including the zero / illegal encodings 32..63).
   full_subtractor_8bits u_shamt_sub (
      .a    (TARGET),
      .b    ({2'b00, lead}),
      .bin  (1'b0),
      .diff (shamt8),
      .bout (b0)
   );

   full_subtractor_8bits u_exp_sub (
      .a    (ex_a),
      .b    (shamt8),
      .bin  (1'b0),
      .diff (ex_diff),
      .bout (ex_bout)
   );

   // Five-stage barrel shifter; when b0=0, shamt8 <= 23 so bits [4:0] carry
   // the full amount.
   always_comb begin
      shifted = sig;
      if (shamt8[0]) shifted = {shifted[30:0], 1'b0};
      if (shamt8[1]) shifted = {shifted[29:0], 2'b0};
      if (shamt8[2]) shifted = {shifted[27:0], 4'b0};
      if (shamt8[3]) shifted = {shifted[23:0], 8'b0};
      if (shamt8[4]) shifted = {shifted[15:0], 16'b0};
   end

   always_comb begin
      sig_sub_d   = shifted;
      ex_sub_d    = ex_diff;
      shift_neg_d = 1'b0;
      ex_borrow_d = ex_bout;
      if (b0) begin
         sig_sub_d   = sig;
         ex_sub_d    = ex_a;
         shift_neg_d = 1'b1;
         ex_borrow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sig_sub_q   <= '0;
         ex_sub_q    <= '0;
         shift_neg_q <= 1'b0;
         ex_borrow_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         // Data registers hold across idle cycles.
         if (in_valid) begin
            sig_sub_q   <= sig_sub_d;
            ex_sub_q    <= ex_sub_d;
            shift_neg_q <= shift_neg_d;
            ex_borrow_q <= ex_borrow_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign sig_sub   = sig_sub_q;
   assign ex_sub    = ex_sub_q;
   assign shift_neg = shift_neg_q;
   assign ex_borrow = ex_borrow_q;

endmodule

// File: tb/tb_shifter_left_32bits.sv
// tb/tb_shifter_left_32bits.sv - table-driven bench for shifter_left_32bits
module tb_shifter_left_32bits;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] sig;
   logic [7:0]  ex_a;
   logic [5:0]  lead;
   logic        out_valid;
   logic [31:0] sig_sub;
   logic [7:0]  ex_sub;
   logic        shift_neg;
   logic        ex_borrow;

   int checks = 0;
   int errors = 0;

   shifter_left_32bits dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .sig       (sig),
      .ex_a      (ex_a),
      .lead      (lead),
      .out_valid (out_valid),
      .sig_sub   (sig_sub),
      .ex_sub    (ex_sub),
      .shift_neg (shift_neg),
      .ex_borrow (ex_borrow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] s;
      logic [7:0]  e;
      logic [5:0]  l;
      logic        x_v;
      logic [31:0] x_s;
      logic [7:0]  x_e;
      logic        x_n;
      logic        x_b;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic xv, input logic [31:0] xs,
                          input logic [7:0] xe, input logic xn, input logic xb);
      chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, xv});
      chk({tag, ".sig_sub"},   sig_sub, xs);
      chk({tag, ".ex_sub"},    {24'b0, ex_sub}, {24'b0, xe});
      chk({tag, ".shift_neg"}, {31'b0, shift_neg}, {31'b0, xn});
      chk({tag, ".ex_borrow"}, {31'b0, ex_borrow}, {31'b0, xb});
   endtask

   task automatic drive(input logic v, input logic [31:0] s, input logic [7:0] e, input logic [5:0] l);
      in_valid = v;
      sig      = s;
      ex_a     = e;
      lead     = l;
   endtask

   initial begin
      //         v     sig           ex     lead   x_v   x_sig         x_ex   neg   bor
      vecs.push_back('{1'b1, 32'h007C9C00, 8'h87, 6'd22, 1'b1, 32'h00F93800, 8'h86, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h0006E800, 8'h8A, 6'd18, 1'b1, 32'h00DD0000, 8'h85, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h006147AF, 8'h7E, 6'd22, 1'b1, 32'h00C28F5E, 8'h7D, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h00000001, 8'h10, 6'd0,  1'b1, 32'h00800000, 8'hF9, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 32'h00ABCDEF, 8'h55, 6'd23, 1'b1, 32'h00ABCDEF, 8'h55, 1'b0, 1'b0});
      // idle cycle: valid drops, data holds the previous result
      vecs.push_back('{1'b0, 32'hFFFFFFFF, 8'hEE, 6'd3,  1'b0, 32'h00ABCDEF, 8'h55, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h80000000, 8'h40, 6'd31, 1'b1, 32'h80000000, 8'h40, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 32'h00000000, 8'h33, 6'd32, 1'b1, 32'h00000000, 8'h33, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 32'h12345678, 8'h99, 6'd40, 1'b1, 32'h12345678, 8'h99, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 32'h00040000, 8'h02, 6'd18, 1'b1, 32'h00800000, 8'hFD, 1'b0, 1'b1});
      // high bits shifted past bit 31 are dropped
      vecs.push_back('{1'b1, 32'hFF000001, 8'h30, 6'd0,  1'b1, 32'h00800000, 8'h19, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 32'h00000400, 8'h17, 6'd10, 1'b1, 32'h00800000, 8'h0A, 1'b0, 1'b0});

      // Reset with arbitrary valid inputs for two cycles.
      rst = 1'b1;
      drive(1'b1, 32'hDEADBEEF, 8'hA5, 6'd5);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk_all($sformatf("reset%0d", c), 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 32'h0, 8'h0, 6'd0);

      // Back-to-back application: each result checked one edge after its input.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].l);
         @(posedge clk); #1;
         chk_all($sformatf("vec%0d", i), vecs[i].x_v, vecs[i].x_s, vecs[i].x_e,
                 vecs[i].x_n, vecs[i].x_b);
      end

      // Idle for one cycle then valid: out_valid low exactly one cycle.
      @(negedge clk);
      drive(1'b0, 32'h00000002, 8'h01, 6'd1);
      @(posedge clk); #1;
      chk_all("gap.idle", 1'b0, 32'h00800000, 8'h0A, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h00000002, 8'h01, 6'd1);
      @(posedge clk); #1;
      // shift 22: 0x2<<22 = 0x00800000, 0x01-0x16 = 0xEB with borrow
      chk_all("gap.resume", 1'b1, 32'h00800000, 8'hEB, 1'b0, 1'b1);

      // Mid-stream reset clears outputs on the next edge.
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 32'h007C9C00, 8'h87, 6'd22);
      @(posedge clk); #1;
      chk_all("midrst", 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_all("post_rst", 1'b1, 32'h00F93800, 8'h86, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
